// File: rtl/fft16_pkg.sv
// ---------------------------------------------------------------------------
// fft16_pkg
// Shared definitions for the 16-point FFT datapath:
//   - sample/twiddle widths and the rounding shift
//   - cplx_t   : packed {re, im} sample, Q1.15 components
//   - cplx18_t : packed {re, im} butterfly sum, 18-bit components
//   - W16_RE/W16_IM : W16^k = (cos(2*pi*k/16), -sin(2*pi*k/16)) in Q2.14,
//     k = 0..9 (the largest exponent a radix-4 first stage needs is 3*3)
//   - sat16()     : clamp a wide accumulator to 16 signed bits
//   - round_sat() : round half-up, shift right by SH, then sat16()
// Build option: BFLY_SCALE_EN selects SH = 16 (results scaled by 1/4);
// without it SH = 14 (unity gain).
// ---------------------------------------------------------------------------
package fft16_pkg;

    localparam int DW  = 16;          // sample component width, Q1.15
    localparam int TW  = 16;          // twiddle component width, Q2.14
    localparam int TWF = TW - 2;      // twiddle fraction bits (+1.0 = 2^14)
    localparam int SW  = DW + 2;      // butterfly sum width
    localparam int PW  = SW + TW;     // one 18x16 product
    localparam int AW  = PW + 1;      // sum of two products
    localparam int NTW = 10;          // twiddle table depth

`ifdef BFLY_SCALE_EN
    localparam int SH = 16;
`else
    localparam int SH = 14;
`endif

    localparam logic signed [AW-1:0] RND = AW'(1) <<< (SH - 1);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [SW-1:0] re;
        logic signed [SW-1:0] im;
    } cplx18_t;

    localparam logic signed [TW-1:0] W16_RE [0:NTW-1] = '{
         16'sd16384,  16'sd15137,  16'sd11585,  16'sd6270,   16'sd0,
        -16'sd6270,  -16'sd11585, -16'sd15137, -16'sd16384, -16'sd15137
    };

    localparam logic signed [TW-1:0] W16_IM [0:NTW-1] = '{
         16'sd0,     -16'sd6270,  -16'sd11585, -16'sd15137, -16'sd16384,
        -16'sd15137, -16'sd11585, -16'sd6270,   16'sd0,      16'sd6270
    };

    // The value fits in DW bits when every bit from the sign down to bit
    // DW-1 agrees; otherwise clamp toward the side the sign bit indicates.
    function automatic logic signed [DW-1:0] sat16(input logic signed [AW-1:0] x);
        logic signed [DW-1:0] r;
        if (!x[AW-1] && (|x[AW-2:DW-1])) begin
            r = 16'sh7FFF;
        end else if (x[AW-1] && !(&x[AW-2:DW-1])) begin
            r = 16'sh8000;
        end else begin
            r = x[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [DW-1:0] round_sat(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] t;
        t = (acc + RND) >>> SH;
        return sat16(t);
    endfunction

endpackage

// File: rtl/fft_cmul.sv
// ---------------------------------------------------------------------------
// fft_cmul
// Registered complex multiply of an 18-bit butterfly output by a Q2.14
// twiddle taken from the shared W16 table, followed by half-up rounding,
// shift by SH and saturation to 16 bits per component.
// Twiddle index 0 (W = 1.0) skips the multipliers; scaling y by 2^14 is
// bit-identical to multiplying by 16384, so the result is unchanged.
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset, clears the output register
//   en_i      load the output register this cycle (holds otherwise)
//   y_i       18-bit complex operand
//   tw_idx_i  twiddle exponent k (0..9) of W16^k
//   z_o       registered 16-bit complex result {re, im}
// Build option: BFLY_SCALE_EN (via fft16_pkg) changes the shift to 16.
// ---------------------------------------------------------------------------
module fft_cmul
    import fft16_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en_i,
    input  cplx18_t     y_i,
    input  logic [3:0]  tw_idx_i,
    output cplx_t       z_o
);

    logic signed [TW-1:0] w_re;
    logic signed [TW-1:0] w_im;
    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ri;
    logic signed [PW-1:0] p_ir;
    logic signed [AW-1:0] acc_re;
    logic signed [AW-1:0] acc_im;
    cplx_t                z_d;
    cplx_t                z_q;

    always_comb begin
        w_re = '0;
        w_im = '0;
        // Exponents above 9 cannot occur; keep them harmless anyway.
        if (tw_idx_i < 4'(NTW)) begin
            w_re = W16_RE[tw_idx_i];
            w_im = W16_IM[tw_idx_i];
        end
    end

    always_comb begin
        p_rr = PW'(y_i.re) * PW'(w_re);
        p_ii = PW'(y_i.im) * PW'(w_im);
        p_ri = PW'(y_i.re) * PW'(w_im);
        p_ir = PW'(y_i.im) * PW'(w_re);
        if (tw_idx_i == 4'd0) begin
            acc_re = AW'(y_i.re) <<< TWF;
            acc_im = AW'(y_i.im) <<< TWF;
        end else begin
            acc_re = AW'(p_rr) - AW'(p_ii);
            acc_im = AW'(p_ri) + AW'(p_ir);
        end
        z_d.re = round_sat(acc_re);
        z_d.im = round_sat(acc_im);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z_q <= '0;
        end else if (en_i) begin
            z_q <= z_d;
        end
    end

    assign z_o = z_q;

endmodule

// File: rtl/radix4_bfly_stage.sv
// ---------------------------------------------------------------------------
// radix4_bfly_stage
// First radix-4 DIF butterfly stage of the 16-point FFT. Each valid cycle
// it accepts the group x[n], x[n+4], x[n+8], x[n+12] with group index n,
// forms the 4-point DFT y0..y3 and multiplies ym by W16^(n*m).
// Three register stages: input capture, butterfly sums, twiddle multiply.
// One group per cycle, no backpressure, 3-cycle latency.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset; empties the pipeline and
//              clears out_valid, out_0..3 and out_idx
//   in_valid   group on in_0..in_3 / in_idx valid this cycle
//   in_0..3    x[n], x[n+4], x[n+8], x[n+12], each {re[31:16], im[15:0]}
//   in_idx     group index n
//   out_valid  out_0..3 / out_idx valid this cycle
//   out_0..3   y0, y1*W^n, y2*W^2n, y3*W^3n, each {re, im}; held when idle
//   out_idx    in_idx of the group being emitted
// Build option: BFLY_SCALE_EN scales all outputs by 1/4 (shift of 16).
// ---------------------------------------------------------------------------
module radix4_bfly_stage
    import fft16_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] in_0,
    input  logic [31:0] in_1,
    input  logic [31:0] in_2,
    input  logic [31:0] in_3,
    input  logic [1:0]  in_idx,
    output logic        out_valid,
    output logic [31:0] out_0,
    output logic [31:0] out_1,
    output logic [31:0] out_2,
    output logic [31:0] out_3,
    output logic [1:0]  out_idx
);

    // ---------------- stage 1: input capture ----------------
    cplx_t      in_arr [0:3];
    cplx_t      x_q    [0:3];
    logic [1:0] idx1_q;
    logic       v1_q;

    assign in_arr[0] = in_0;
    assign in_arr[1] = in_1;
    assign in_arr[2] = in_2;
    assign in_arr[3] = in_3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q   <= 1'b0;
            idx1_q <= '0;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                idx1_q <= in_idx;
                for (int i = 0; i < 4; i++) begin
                    x_q[i] <= in_arr[i];
                end
            end
        end
    end

    // ---------------- stage 2: 4-point DFT ----------------
    logic signed [SW-1:0] ar, ai, br, bi, cr, ci, dr, di;
    logic signed [SW-1:0] sac_r, sac_i, dac_r, dac_i;
    logic signed [SW-1:0] sbd_r, sbd_i, dbd_r, dbd_i;
    cplx18_t              y_d [0:3];
    cplx18_t              y_q [0:3];
    logic [1:0]           idx2_q;
    logic                 v2_q;

    always_comb begin
        ar = SW'(x_q[0].re);  ai = SW'(x_q[0].im);
        br = SW'(x_q[1].re);  bi = SW'(x_q[1].im);
        cr = SW'(x_q[2].re);  ci = SW'(x_q[2].im);
        dr = SW'(x_q[3].re);  di = SW'(x_q[3].im);

        sac_r = ar + cr;  sac_i = ai + ci;
        dac_r = ar - cr;  dac_i = ai - ci;
        sbd_r = br + dr;  sbd_i = bi + di;
        dbd_r = br - dr;  dbd_i = bi - di;

        y_d[0].re = sac_r + sbd_r;
        y_d[0].im = sac_i + sbd_i;
        y_d[2].re = sac_r - sbd_r;
        y_d[2].im = sac_i - sbd_i;
        // -j*(p + jq) = q - jp, +j*(p + jq) = -q + jp
        y_d[1].re = dac_r + dbd_i;
        y_d[1].im = dac_i - dbd_r;
        y_d[3].re = dac_r - dbd_i;
        y_d[3].im = dac_i + dbd_r;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2_q   <= 1'b0;
            idx2_q <= '0;
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                idx2_q <= idx1_q;
                for (int i = 0; i < 4; i++) begin
                    y_q[i] <= y_d[i];
                end
            end
        end
    end

    // ---------------- stage 3: twiddle multiply ----------------
    // y0 always meets W^0, so it only needs the rounding/saturation path.
    logic signed [AW-1:0] acc0_re;
    logic signed [AW-1:0] acc0_im;
    cplx_t                z0_d;
    cplx_t                z0_q;
    cplx_t                z      [0:3];
    logic [3:0]           tw_idx [1:3];
    logic                 out_valid_q;
    logic [1:0]           out_idx_q;

    always_comb begin
        acc0_re = AW'(y_q[0].re) <<< TWF;
        acc0_im = AW'(y_q[0].im) <<< TWF;
        z0_d.re = round_sat(acc0_re);
        z0_d.im = round_sat(acc0_im);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z0_q        <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                z0_q      <= z0_d;
                out_idx_q <= idx2_q;
            end
        end
    end

    assign z[0] = z0_q;

    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_cmul
            assign tw_idx[gi] = 4'(idx2_q) * 4'(gi);

            fft_cmul u_cmul (
                .clk      (clk),
                .reset_n  (reset_n),
                .en_i     (v2_q),
                .y_i      (y_q[gi]),
                .tw_idx_i (tw_idx[gi]),
                .z_o      (z[gi])
            );
        end
    endgenerate

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_0     = z[0];
    assign out_1     = z[1];
    assign out_2     = z[2];
    assign out_3     = z[3];

endmodule

// File: tb/tb_radix4_bfly_stage.sv
// ---------------------------------------------------------------------------
// tb_radix4_bfly_stage
// Directed scenarios plus a randomized stream checked against a reference
// built from the 4-point DFT definition, twiddles computed with $cos/$sin.
// ---------------------------------------------------------------------------
module tb_radix4_bfly_stage;

`ifdef BFLY_SCALE_EN
    localparam int SH = 16;
`else
    localparam int SH = 14;
`endif
    localparam real PI_R = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_0, in_1, in_2, in_3;
    logic [1:0]  in_idx;
    logic        out_valid;
    logic [31:0] out_0, out_1, out_2, out_3;
    logic [1:0]  out_idx;

    always #5 clk = ~clk;

    radix4_bfly_stage dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_0      (in_0),
        .in_1      (in_1),
        .in_2      (in_2),
        .in_3      (in_3),
        .in_idx    (in_idx),
        .out_valid (out_valid),
        .out_0     (out_0),
        .out_1     (out_1),
        .out_2     (out_2),
        .out_3     (out_3),
        .out_idx   (out_idx)
    );

    int     n_cmp = 0;
    int     n_err = 0;
    longint tw_re [10];
    longint tw_im [10];

    typedef struct packed {
        int              cyc;
        logic [1:0]      idx;
        logic [3:0][31:0] o;
    } exp_t;

    // ---------------- reference model ----------------
    function automatic longint rnd_q14(input real v);
        if (v >= 0.0) return longint'($rtoi(v + 0.5));
        return -longint'($rtoi(-v + 0.5));
    endfunction

    task automatic init_twiddles();
        for (int k = 0; k < 10; k++) begin
            tw_re[k] = rnd_q14( 16384.0 * $cos(2.0 * PI_R * real'(k) / 16.0));
            tw_im[k] = rnd_q14(-16384.0 * $sin(2.0 * PI_R * real'(k) / 16.0));
        end
    endtask

    function automatic logic [15:0] sat_ref(input longint v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    // Output m of the group: y_m = sum_k x_k * (-j)^(m*k), then * W16^(n*m).
    function automatic logic [31:0] ref_out(input int m, input logic [1:0] n,
                                            input logic [31:0] x0, input logic [31:0] x1,
                                            input logic [31:0] x2, input logic [31:0] x3);
        logic [31:0] xs [4];
        longint xr, xi, yr, yi, wr, wi, qr, qi;
        int kk;
        xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
        yr = 0; yi = 0;
        for (int k = 0; k < 4; k++) begin
            xr = longint'($signed(xs[k][31:16]));
            xi = longint'($signed(xs[k][15:0]));
            case ((m * k) % 4)
                0: begin yr += xr; yi += xi; end
                1: begin yr += xi; yi -= xr; end
                2: begin yr -= xr; yi -= xi; end
                default: begin yr -= xi; yi += xr; end
            endcase
        end
        kk = int'(n) * m;
        wr = tw_re[kk];
        wi = tw_im[kk];
        qr = yr * wr - yi * wi;
        qi = yr * wi + yi * wr;
        qr = (qr + (64'sd1 <<< (SH - 1))) >>> SH;
        qi = (qi + (64'sd1 <<< (SH - 1))) >>> SH;
        return {sat_ref(qr), sat_ref(qi)};
    endfunction

    function automatic logic [3:0][31:0] ref_group(input logic [1:0] n,
                                                   input logic [31:0] x0, input logic [31:0] x1,
                                                   input logic [31:0] x2, input logic [31:0] x3);
        logic [3:0][31:0] r;
        for (int m = 0; m < 4; m++) r[m] = ref_out(m, n, x0, x1, x2, x3);
        return r;
    endfunction

    function automatic logic [15:0] rcomp();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive(input logic v, input logic [1:0] idx,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        in_valid = v;
        in_idx   = idx;
        in_0 = a; in_1 = b; in_2 = c; in_3 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0][31:0] o;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_idx   = 2'd3;
        in_0 = 32'h1234_5678; in_1 = 32'h0F0F_F0F0; in_2 = 32'h7FFF_8000; in_3 = 32'h0001_0001;
        repeat (4) @(posedge clk);
        #1;
        o = {out_3, out_2, out_1, out_0};
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        n_cmp++;
        if (out_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx got=%0d want=0", out_idx); end
        for (int m = 0; m < 4; m++) begin
            n_cmp++;
            if (o[m] !== 32'h0) begin n_err++; $display("FAIL reset_out%0d got=%h want=00000000", m, o[m]); end
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        $display("test_reset: out_valid=%b out_idx=%0d out_0=%h", out_valid, out_idx, out_0);
    endtask

    task automatic test_impulse();
        logic [3:0][31:0] e, o;
        logic [31:0] want0, want2;
`ifdef BFLY_SCALE_EN
        want0 = 32'h0800_0000; want2 = 32'h0000_F800;
`else
        want0 = 32'h2000_0000; want2 = 32'h0000_E000;
`endif
        e = ref_group(2'd2, 32'h2000_0000, 32'h0, 32'h0, 32'h0);
        drive(1'b1, 2'd2, 32'h2000_0000, 32'h0, 32'h0, 32'h0);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        o = {out_3, out_2, out_1, out_0};
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL impulse_valid got=%b want=1", out_valid); end
        n_cmp++;
        if (out_idx !== 2'd2) begin n_err++; $display("FAIL impulse_idx got=%0d want=2", out_idx); end
        n_cmp++;
        if (o[0] !== want0) begin n_err++; $display("FAIL impulse_out0 got=%h want=%h", o[0], want0); end
        n_cmp++;
        if (o[2] !== want2) begin n_err++; $display("FAIL impulse_out2 got=%h want=%h", o[2], want2); end
        n_cmp++;
        if (o[1] !== e[1]) begin n_err++; $display("FAIL impulse_out1 got=%h want=%h", o[1], e[1]); end
        n_cmp++;
        if (o[3] !== e[3]) begin n_err++; $display("FAIL impulse_out3 got=%h want=%h", o[3], e[3]); end
        $display("test_impulse: idx=%0d out=%h %h %h %h", out_idx, o[0], o[1], o[2], o[3]);
        // One more idle cycle: valid drops, data holds.
        drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        o = {out_3, out_2, out_1, out_0};
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL impulse_bubble_valid got=%b want=0", out_valid); end
        for (int m = 0; m < 4; m++) begin
            n_cmp++;
            if (o[m] !== e[m]) begin n_err++; $display("FAIL impulse_hold_out%0d got=%h want=%h", m, o[m], e[m]); end
        end
    endtask

    task automatic test_dc_and_negfs();
        logic [3:0][31:0] o;
        logic [31:0] dc_in  [2];
        logic [31:0] dc_out [2];
        dc_in[0] = 32'h4000_0000;
        dc_in[1] = 32'h8000_8000;
`ifdef BFLY_SCALE_EN
        dc_out[0] = 32'h4000_0000;
`else
        dc_out[0] = 32'h7FFF_0000;
`endif
        dc_out[1] = 32'h8000_8000;
        for (int t = 0; t < 2; t++) begin
            drive(1'b1, 2'd0, dc_in[t], dc_in[t], dc_in[t], dc_in[t]);
            drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
            drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
            o = {out_3, out_2, out_1, out_0};
            n_cmp++;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL dc%0d_valid got=%b want=1", t, out_valid); end
            n_cmp++;
            if (o[0] !== dc_out[t]) begin n_err++; $display("FAIL dc%0d_out0 got=%h want=%h", t, o[0], dc_out[t]); end
            for (int m = 1; m < 4; m++) begin
                n_cmp++;
                if (o[m] !== 32'h0) begin n_err++; $display("FAIL dc%0d_out%0d got=%h want=00000000", t, m, o[m]); end
            end
            $display("test_dc[%0d]: in=%h out=%h %h %h %h", t, dc_in[t], o[0], o[1], o[2], o[3]);
        end
    endtask

    task automatic test_streaming();
        logic [3:0][31:0] e [4];
        logic [31:0]      g [4][4];
        logic [3:0][31:0] o;
        logic             ev;
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 4; s++) g[k][s] = {rcomp(), rcomp()};
            e[k] = ref_group(2'(k), g[k][0], g[k][1], g[k][2], g[k][3]);
        end
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(1'b1, 2'(c), g[c][0], g[c][1], g[c][2], g[c][3]);
            else       drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
            o  = {out_3, out_2, out_1, out_0};
            ev = (c >= 2) && (c <= 5);
            n_cmp++;
            if (out_valid !== ev) begin n_err++; $display("FAIL stream_valid c=%0d got=%b want=%b", c, out_valid, ev); end
            if (c >= 2) begin
                n_cmp++;
                if (out_idx !== 2'((c <= 5) ? c - 2 : 3))
                    begin n_err++; $display("FAIL stream_idx c=%0d got=%0d want=%0d", c, out_idx, (c <= 5) ? c - 2 : 3); end
                for (int m = 0; m < 4; m++) begin
                    n_cmp++;
                    if (o[m] !== e[(c <= 5) ? c - 2 : 3][m])
                        begin n_err++; $display("FAIL stream_out%0d c=%0d got=%h want=%h", m, c, o[m], e[(c <= 5) ? c - 2 : 3][m]); end
                end
            end
            $display("test_streaming c=%0d: valid=%b idx=%0d out_0=%h", c, out_valid, out_idx, out_0);
        end
    endtask

    task automatic test_reset_midstream();
        logic [3:0][31:0] o, e;
        logic [31:0] a, b, c, d;
        drive(1'b1, 2'd1, {rcomp(), rcomp()}, {rcomp(), rcomp()}, {rcomp(), rcomp()}, {rcomp(), rcomp()});
        drive(1'b1, 2'd3, {rcomp(), rcomp()}, {rcomp(), rcomp()}, {rcomp(), rcomp()}, {rcomp(), rcomp()});
        in_valid = 1'b0;
        reset_n  = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) #1;
            else begin @(posedge clk); #1; end
            o = {out_3, out_2, out_1, out_0};
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst%0d_valid got=%b want=0", p, out_valid); end
            n_cmp++;
            if (out_idx !== 2'd0) begin n_err++; $display("FAIL midrst%0d_idx got=%0d want=0", p, out_idx); end
            for (int m = 0; m < 4; m++) begin
                n_cmp++;
                if (o[m] !== 32'h0) begin n_err++; $display("FAIL midrst%0d_out%0d got=%h want=00000000", p, m, o[m]); end
            end
        end
        reset_n = 1'b1;
        for (int p = 0; p < 3; p++) begin
            drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_flush%0d_valid got=%b want=0", p, out_valid); end
        end
        a = {rcomp(), rcomp()}; b = {rcomp(), rcomp()}; c = {rcomp(), rcomp()}; d = {rcomp(), rcomp()};
        e = ref_group(2'd2, a, b, c, d);
        for (int p = 0; p < 3; p++) begin
            if (p == 0) drive(1'b1, 2'd2, a, b, c, d);
            else        drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
            n_cmp++;
            if (out_valid !== (p == 2)) begin n_err++; $display("FAIL midrst_next%0d_valid got=%b want=%b", p, out_valid, p == 2); end
        end
        o = {out_3, out_2, out_1, out_0};
        n_cmp++;
        if (out_idx !== 2'd2) begin n_err++; $display("FAIL midrst_next_idx got=%0d want=2", out_idx); end
        for (int m = 0; m < 4; m++) begin
            n_cmp++;
            if (o[m] !== e[m]) begin n_err++; $display("FAIL midrst_next_out%0d got=%h want=%h", m, o[m], e[m]); end
        end
        $display("test_reset_midstream: next idx=%0d out=%h %h %h %h", out_idx, o[0], o[1], o[2], o[3]);
    endtask

    task automatic test_random();
        exp_t             q [$];
        exp_t             r;
        logic [3:0][31:0] held, o;
        logic [1:0]       held_idx;
        logic [31:0]      x [4];
        logic             v, ev;
        logic [1:0]       idx;
        int               n_groups = 0;
        int               n_out = 0;
        int               cyc = 0;
        apply_reset();
        held = '0;
        held_idx = '0;
        while ((n_groups < 10000 || q.size() > 0) && cyc < 20000) begin
            v   = (n_groups < 10000) && ($urandom_range(0, 3) != 0);
            idx = 2'($urandom_range(0, 3));
            for (int s = 0; s < 4; s++)
                x[s] = ($urandom_range(0, 1) == 0) ? $urandom : {rcomp(), rcomp()};
            if (v) begin
                r.cyc = cyc;
                r.idx = idx;
                r.o   = ref_group(idx, x[0], x[1], x[2], x[3]);
                q.push_back(r);
                n_groups++;
            end
            drive(v, idx, x[0], x[1], x[2], x[3]);
            ev = (q.size() > 0) && (q[0].cyc == cyc - 2);
            if (ev) begin
                held     = q[0].o;
                held_idx = q[0].idx;
                void'(q.pop_front());
            end
            o = {out_3, out_2, out_1, out_0};
            n_cmp++;
            if (out_valid !== ev) begin n_err++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", cyc, out_valid, ev); end
            n_cmp++;
            if (out_idx !== held_idx) begin n_err++; $display("FAIL rand_idx cyc=%0d got=%0d want=%0d", cyc, out_idx, held_idx); end
            for (int m = 0; m < 4; m++) begin
                n_cmp++;
                if (o[m] !== held[m]) begin n_err++; $display("FAIL rand_out%0d cyc=%0d got=%h want=%h", m, cyc, o[m], held[m]); end
            end
            if (ev) begin
                $display("rand txn %0d cyc=%0d idx=%0d out=%h %h %h %h", n_out, cyc, held_idx, o[0], o[1], o[2], o[3]);
                n_out++;
            end
            cyc++;
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL rand_drain pending=%0d want=0 (cycle budget expired)", q.size()); end
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_idx   = '0;
        in_0 = '0; in_1 = '0; in_2 = '0; in_3 = '0;
        init_twiddles();
        test_reset();
        test_impulse();
        test_dc_and_negfs();
        test_streaming();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
